// File: rtl/ysyx_20020207_lsu_axi_split.sv
// Load/store unit with one outstanding request behind an AXI4-lite-style master.
// Accesses straddling a bus word become two aligned beats (low word first, then high word).
module ysyx_20020207_lsu_axi_split #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_wen_i,
    input  logic [ADDR_W-1:0]     req_addr_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [31:0]           req_wdata_i,

    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [31:0]           resp_rdata_o,
    output logic                  resp_err_o,

    output logic                  arvalid_o,
    input  logic                  arready_i,
    output logic [ADDR_W-1:0]     araddr_o,

    input  logic                  rvalid_i,
    output logic                  rready_o,
    input  logic [DATA_W-1:0]     rdata_i,
    input  logic [1:0]            rresp_i,

    output logic                  awvalid_o,
    input  logic                  awready_i,
    output logic [ADDR_W-1:0]     awaddr_o,

    output logic                  wvalid_o,
    input  logic                  wready_i,
    output logic [DATA_W-1:0]     wdata_o,
    output logic [DATA_W/8-1:0]   wstrb_o,

    input  logic                  bvalid_i,
    output logic                  bready_o,
    input  logic [1:0]            bresp_i
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFS_W = $clog2(BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RA,
        S_RD,
        S_WA,
        S_WB,
        S_MID,
        S_RSP
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic                wen_q, wen_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                beat_q, beat_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rbeat0_q, rbeat0_d;
    logic [DATA_W-1:0]   rbeat1_q, rbeat1_d;

    // ------------------------------------------------------------------
    // Access geometry, derived from the latched request
    // ------------------------------------------------------------------
    logic [OFS_W-1:0]    ofs;
    logic [OFS_W+2:0]    bit_ofs;
    logic [ADDR_W-1:0]   base_addr;
    logic [ADDR_W-1:0]   high_addr;
    logic [ADDR_W-1:0]   beat_addr;
    logic [3:0]          mask4;
    logic [2*BYTES-1:0]  m2;
    logic [2*DATA_W-1:0] d2;
    logic                split;

    assign ofs       = addr_q[OFS_W-1:0];
    assign bit_ofs   = {ofs, 3'b000};
    assign base_addr = {addr_q[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
    assign high_addr = base_addr + ADDR_W'(BYTES);
    assign beat_addr = beat_q ? high_addr : base_addr;

    always_comb begin
        case (size_q)
            2'd0:    mask4 = 4'b0001;
            2'd1:    mask4 = 4'b0011;
            default: mask4 = 4'b1111;
        endcase
    end

    assign m2    = {{(2*BYTES-4){1'b0}}, mask4} << ofs;
    assign d2    = {{(2*DATA_W-32){1'b0}}, wdata_q} << bit_ofs;
    assign split = |m2[2*BYTES-1:BYTES];

    // ------------------------------------------------------------------
    // Load realignment and extension
    // ------------------------------------------------------------------
    logic [31:0] rd_word;
    logic [31:0] rd_ext;

    assign rd_word = 32'({rbeat1_q, rbeat0_q} >> bit_ofs);

    always_comb begin
        case (size_q)
            2'd0:    rd_ext = uns_q ? {24'b0, rd_word[7:0]}
                                    : {{24{rd_word[7]}}, rd_word[7:0]};
            2'd1:    rd_ext = uns_q ? {16'b0, rd_word[15:0]}
                                    : {{16{rd_word[15]}}, rd_word[15:0]};
            default: rd_ext = rd_word;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs are pure functions of state, so reset clears them at once
    // ------------------------------------------------------------------
    assign req_ready_o  = (state_q == S_IDLE);
    assign arvalid_o    = (state_q == S_RA);
    assign araddr_o     = beat_addr;
    assign rready_o     = (state_q == S_RD);
    assign awvalid_o    = (state_q == S_WA) && !aw_done_q;
    assign awaddr_o     = beat_addr;
    assign wvalid_o     = (state_q == S_WA) && !w_done_q;
    assign wdata_o      = beat_q ? d2[2*DATA_W-1:DATA_W] : d2[DATA_W-1:0];
    assign wstrb_o      = beat_q ? m2[2*BYTES-1:BYTES] : m2[BYTES-1:0];
    assign bready_o     = (state_q == S_WB);
    assign resp_valid_o = (state_q == S_RSP);
    assign resp_err_o   = (state_q == S_RSP) && err_q;
    assign resp_rdata_o = ((state_q == S_RSP) && !wen_q && !err_q) ? rd_ext : 32'b0;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        uns_d     = uns_q;
        wen_d     = wen_q;
        wdata_d   = wdata_q;
        beat_d    = beat_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        err_d     = err_q;
        rbeat0_d  = rbeat0_q;
        rbeat1_d  = rbeat1_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    addr_d    = req_addr_i;
                    size_d    = req_size_i;
                    uns_d     = req_unsigned_i;
                    wen_d     = req_wen_i;
                    wdata_d   = req_wdata_i;
                    beat_d    = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    err_d     = 1'b0;
                    rbeat0_d  = '0;
                    rbeat1_d  = '0;
                    state_d   = req_wen_i ? S_WA : S_RA;
                end
            end

            S_RA: begin
                if (arready_i) state_d = S_RD;
            end

            S_RD: begin
                if (rvalid_i) begin
                    if (beat_q) rbeat1_d = rdata_i;
                    else        rbeat0_d = rdata_i;
                    if (rresp_i != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = S_RSP;
                    end else if (!beat_q && split) begin
                        state_d = S_MID;
                    end else begin
                        state_d = S_RSP;
                    end
                end
            end

            S_WA: begin
                // Address and data channels complete independently, in either order.
                aw_done_d = aw_done_q | awready_i;
                w_done_d  = w_done_q | wready_i;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_WB;
                end
            end

            S_WB: begin
                if (bvalid_i) begin
                    if (bresp_i != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = S_RSP;
                    end else if (!beat_q && split) begin
                        state_d = S_MID;
                    end else begin
                        state_d = S_RSP;
                    end
                end
            end

            S_MID: begin
                beat_d  = 1'b1;
                state_d = wen_q ? S_WA : S_RA;
            end

            S_RSP: begin
                if (resp_ready_i) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            beat_q    <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
            rbeat0_q  <= '0;
            rbeat1_q  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            wen_q     <= wen_d;
            wdata_q   <= wdata_d;
            beat_q    <= beat_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
            rbeat0_q  <= rbeat0_d;
            rbeat1_q  <= rbeat1_d;
        end
    end

endmodule
